frm_buf_sched: RTL
==================

// Module: frm_buf_sched
// PURPOSE
//  Frame-buffer scheduler for the video write/read path. Consumes the per-frame
//  completion pulse from the frame-complete detector and the reader's frame-start
//  pulse, and hands out rotating buffer indices to the writer (DMA/S2MM) and the
//  reader (display/MM2S) so that neither ever touches the same buffer.
//  Also raises a latched frame IRQ and counts frames dropped because the reader lagged.
// PARAMETERS
//  NUM_BUF   3   number of frame buffers; legal range 3..4
//  IDX_W     2   width of buffer index; must equal clog2(NUM_BUF)
//  DROP_W    16  width of the dropped-frame counter
// PORTS
//  s_axis_aclk     in   1       sole clock
//  s_axis_aresetn  in   1       synchronous reset, active-low
//  enable          in   1       level; 1 = schedule, 0 = park in IDLE
//  frm_cmp         in   1       1-cycle pulse: writer finished current frame
//  rd_frm_start    in   1       1-cycle pulse: reader begins a new frame
//  irq_ack         in   1       1-cycle pulse: software acknowledges frm_irq
//  wr_buf_idx      out  IDX_W   buffer the writer fills
//  rd_buf_idx      out  IDX_W   buffer the reader scans
//  frm_ready       out  1       completed, not-yet-read frame held in latest slot
//  frm_irq         out  1       level interrupt, set per completed frame
//  drop_cnt        out  DROP_W  completed frames discarded unread, saturating
// BEHAVIOUR
//  - All outputs registered; every update is visible the cycle after the input event.
//  - Reset (aresetn=0 at clock edge): state=IDLE, wr_buf_idx=0, rd_buf_idx=0,
//    latest=0, frm_ready=0, frm_irq=0, drop_cnt=0. Reset mid-frame discards all state.
//  - FSM IDLE: wr=0, rd=1, frm_ready=0, frm_irq=0; frm_cmp/rd_frm_start ignored.
//    IDLE -> RUN when enable=1. RUN -> IDLE when enable=0 (wr/rd/ready/irq
//    return to IDLE values next cycle; drop_cnt holds).
//  - Internal: latest (IDX_W) = index of newest completed frame, valid = frm_ready.
//  - RUN, frm_cmp only: latest<=wr; frm_ready<=1; frm_irq<=1;
//    wr<=pick(excl rd, old wr); if frm_ready was 1, drop_cnt++ (old latest overwritten).
//  - RUN, rd_frm_start only: if frm_ready: rd<=latest, frm_ready<=0;
//    else rd unchanged (reader repeats frame), no drop.
//  - RUN, both same cycle: reader takes the just-finished frame: rd<=wr,
//    frm_ready<=0, frm_irq<=1, wr<=pick(excl old wr); if frm_ready was 1, drop_cnt++.
//  - pick(): lowest index in 0..NUM_BUF-1 not in the exclusion set; with NUM_BUF>=3
//    a free index always exists. Invariant: wr != rd, and wr != latest when frm_ready=1.
//  - frm_irq: cleared by irq_ack; set and ack in same cycle -> stays 1 (set wins).
//    Ack while 0 has no effect.
//  - drop_cnt saturates at all-ones, no wrap.
//  - enable=0 coincident with frm_cmp: enable wins, event ignored.
// STRUCTURE
//  - Shared package frm_pkg: FSM state enum {IDLE,RUN}, NUM_BUF/IDX_W defaults,
//    constant DROP_MAX; reused by other frame-path controllers.
//  - One sub-module: frm_buf_pick (combinational lowest-free-index picker,
//    inputs: two exclusion indices + valid bits, output: IDX_W index).
//  - Top: FSM, index/latest/ready registers, irq latch, drop counter.
// TESTING
//  1 reset: aresetn=0 two cycles, enable=1 -> wr=0 rd=0 ready=0 irq=0 drop=0;
//    first cycle in RUN -> wr=0 rd=1.
//  2 steady: frm_cmp, 3 cycles later rd_frm_start -> after frm_cmp wr=2 latest=0
//    ready=1 irq=1; after start rd=0 ready=0; next frm_cmp wr=1.
//  3 reader lag: 3 frm_cmp with no rd_frm_start -> drop_cnt=2, wr never equals rd=1,
//    ready=1 throughout; rd_frm_start then rd=latest of 3rd frame.
//  4 simultaneous: ready=1, frm_cmp & rd_frm_start same cycle with wr=2 ->
//    rd=2, ready=0, drop_cnt+1, wr=0 (lowest free), irq=1.
//  5 irq: irq_ack with frm_cmp same cycle -> frm_irq stays 1; lone ack next -> 0.
//  6 disable: enable=0 mid-run, drop_cnt=5 -> next cycle wr=0 rd=1 ready=0 irq=0
//    drop_cnt=5; frm_cmp while IDLE -> no change; saturation with DROP_W=2: 4 drops -> 3.

Source files
------------

// File: rtl/frm_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : frm_pkg
//  Purpose  : Shared types and defaults for the frame-path controllers.
//  Revision : 1.0 - initial release
// ============================================================================
package frm_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } frm_state_e;

    localparam int unsigned c_num_buf_def = 3;
    localparam int unsigned c_idx_w_def   = 2;
    localparam int unsigned c_drop_w_def  = 16;
    localparam logic [c_drop_w_def-1:0] c_drop_max = '1;

endpackage : frm_pkg
`default_nettype wire

// File: rtl/frm_buf_pick.sv
`default_nettype none
// ============================================================================
//  Module   : frm_buf_pick
//  Purpose  : Combinational picker returning the lowest buffer index that is
//             not in a two-entry exclusion set.
//  Revision : 1.0 - initial release
// ============================================================================
module frm_buf_pick
    import frm_pkg::*;
#(
    parameter int NUM_BUF = c_num_buf_def,
    parameter int IDX_W   = c_idx_w_def
) (
    input  logic [IDX_W-1:0] excl_a,
    input  logic             excl_a_vld,
    input  logic [IDX_W-1:0] excl_b,
    input  logic             excl_b_vld,
    output logic [IDX_W-1:0] idx
);

    logic [IDX_W-1:0] w_cand;

    // Scanning downward lets the last hit, i.e. the lowest free index, win.
    always_comb begin
        idx    = '0;
        w_cand = '0;
        for (int i = NUM_BUF - 1; i >= 0; i--) begin
            w_cand = i[IDX_W-1:0];
            if (!(excl_a_vld && (excl_a == w_cand)) &&
                !(excl_b_vld && (excl_b == w_cand))) begin
                idx = w_cand;
            end
        end
    end

endmodule : frm_buf_pick
`default_nettype wire

// File: rtl/frm_buf_sched.sv
`default_nettype none
// ============================================================================
//  Module   : frm_buf_sched
//  Purpose  : Rotating frame-buffer scheduler for writer/reader, with latched
//             frame IRQ and saturating dropped-frame counter.
//  Revision : 1.0 - initial release
// ============================================================================
module frm_buf_sched
    import frm_pkg::*;
#(
    parameter int NUM_BUF = c_num_buf_def,
    parameter int IDX_W   = c_idx_w_def,
    parameter int DROP_W  = c_drop_w_def
) (
    input  logic              s_axis_aclk,
    input  logic              s_axis_aresetn,
    input  logic              enable,
    input  logic              frm_cmp,
    input  logic              rd_frm_start,
    input  logic              irq_ack,
    output logic [IDX_W-1:0]  wr_buf_idx,
    output logic [IDX_W-1:0]  rd_buf_idx,
    output logic              frm_ready,
    output logic              frm_irq,
    output logic [DROP_W-1:0] drop_cnt
);

    localparam logic [IDX_W-1:0]  c_rd_idle  = IDX_W'(1);
    localparam logic [DROP_W-1:0] c_drop_sat = '1;

    frm_state_e        r_state;
    frm_state_e        w_state_nxt;
    logic              w_run;
    logic [IDX_W-1:0]  w_pick;
    logic [IDX_W-1:0]  r_wr;
    logic [IDX_W-1:0]  r_rd;
    logic [IDX_W-1:0]  r_latest;
    logic              r_ready;
    logic              r_irq;
    logic [DROP_W-1:0] r_drop;

    always_ff @(posedge s_axis_aclk) begin
        if (!s_axis_aresetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_run       = 1'b0;
        case (r_state)
            ST_IDLE: if (enable) w_state_nxt = ST_RUN;
            ST_RUN: begin
                if (!enable) w_state_nxt = ST_IDLE;
                else         w_run       = 1'b1;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // When the reader grabs the finishing frame in the same cycle, only the
    // old write index stays busy, so the reader's index is not excluded.
    frm_buf_pick #(
        .NUM_BUF (NUM_BUF),
        .IDX_W   (IDX_W)
    ) u_pick (
        .excl_a     (r_wr),
        .excl_a_vld (1'b1),
        .excl_b     (r_rd),
        .excl_b_vld (~rd_frm_start),
        .idx        (w_pick)
    );

    always_ff @(posedge s_axis_aclk) begin
        if (!s_axis_aresetn) begin
            r_wr     <= '0;
            r_rd     <= '0;
            r_latest <= '0;
            r_ready  <= 1'b0;
            r_irq    <= 1'b0;
            r_drop   <= '0;
        end else if (!w_run) begin
            r_wr     <= '0;
            r_rd     <= c_rd_idle;
            r_latest <= '0;
            r_ready  <= 1'b0;
            r_irq    <= 1'b0;
        end else if (frm_cmp) begin
            r_latest <= r_wr;
            r_wr     <= w_pick;
            r_irq    <= 1'b1;
            if (r_ready && (r_drop != c_drop_sat)) begin
                r_drop <= r_drop + DROP_W'(1);
            end
            if (rd_frm_start) begin
                r_rd    <= r_wr;
                r_ready <= 1'b0;
            end else begin
                r_ready <= 1'b1;
            end
        end else begin
            if (rd_frm_start && r_ready) begin
                r_rd    <= r_latest;
                r_ready <= 1'b0;
            end
            if (irq_ack) begin
                r_irq <= 1'b0;
            end
        end
    end

    assign wr_buf_idx = r_wr;
    assign rd_buf_idx = r_rd;
    assign frm_ready  = r_ready;
    assign frm_irq    = r_irq;
    assign drop_cnt   = r_drop;

endmodule : frm_buf_sched
`default_nettype wire
